// File: rtl/ascon_job_ctrl_if.sv
// Job/result handshake bundle between the PS-side logic and ascon_job_ctrl.
// master: job producer / result consumer (PS side).
// slave:  the job controller.
//   job_valid/job_ready/job_word: descriptor offer and acceptance.
//   res_valid/res_ready: result hold and take.
//   res_ct/res_pt/res_auth_fail/res_err/res_id: captured result payload.
interface ascon_job_ctrl_if;
    localparam int unsigned DESC_W = 192;
    localparam int unsigned CT_W   = 384;
    localparam int unsigned PT_W   = 256;
    localparam int unsigned ID_W   = 8;

    logic              job_valid;
    logic              job_ready;
    logic [DESC_W-1:0] job_word;
    logic              res_valid;
    logic              res_ready;
    logic [CT_W-1:0]   res_ct;
    logic [PT_W-1:0]   res_pt;
    logic              res_auth_fail;
    logic              res_err;
    logic [ID_W-1:0]   res_id;

    modport master (
        output job_valid, job_word, res_ready,
        input  job_ready, res_valid, res_ct, res_pt, res_auth_fail, res_err, res_id
    );

    modport slave (
        input  job_valid, job_word, res_ready,
        output job_ready, res_valid, res_ct, res_pt, res_auth_fail, res_err, res_id
    );
endinterface

// File: rtl/ascon_job_ctrl.sv
// Sequences one descriptor at a time into the fixed-key ASCON core: holds it on
// core_in for SETTLE cycles, captures ct/pt, flags tag mismatch, rejects bad
// lengths without running the core, and counts completed/failed results.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   bus (slave)     : job offer/accept and result hold/take handshake + payload
//   core_in         : registered descriptor to the core's ps_in
//   core_ct/core_pt : core outputs (pt all-ones = tag mismatch)
//   abort           : cancel a running job
//   done_cnt        : completed results (wraps)
//   fail_cnt        : auth-failed results (saturates)
module ascon_job_ctrl #(
    parameter int unsigned SETTLE = 24,
    parameter int unsigned MAXLEN = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    ascon_job_ctrl_if.slave        bus,
    output logic [191:0]           core_in,
    input  logic [383:0]           core_ct,
    input  logic [255:0]           core_pt,
    input  logic                   abort,
    output logic [15:0]            done_cnt,
    output logic [15:0]            fail_cnt
);
    localparam int unsigned CNT_W = 8;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_RESULT = 2'd2;

    logic [1:0]       r_state,     w_state;
    logic [CNT_W-1:0] r_cnt,       w_cnt;
    logic [7:0]       r_next_id,   w_next_id;
    logic [191:0]     r_core_in,   w_core_in;
    logic             r_job_ready, w_job_ready;
    logic             r_res_valid, w_res_valid;
    logic [383:0]     r_res_ct,    w_res_ct;
    logic [255:0]     r_res_pt,    w_res_pt;
    logic             r_auth_fail, w_auth_fail;
    logic             r_err,       w_err;
    logic [7:0]       r_res_id,    w_res_id;
    logic [15:0]      r_done_cnt,  w_done_cnt;
    logic [15:0]      r_fail_cnt,  w_fail_cnt;

    logic w_accept;
    logic w_len_bad;

    // r_job_ready is high exactly when the FSM sits in IDLE outside reset
    assign w_accept  = r_job_ready & bus.job_valid;
    assign w_len_bad = (bus.job_word[159:128] > 32'(MAXLEN)) ||
                       (bus.job_word[95:64]   > 32'(MAXLEN));

    // Next-state and next-register values
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_next_id   = r_next_id;
        w_core_in   = r_core_in;
        w_res_ct    = r_res_ct;
        w_res_pt    = r_res_pt;
        w_auth_fail = r_auth_fail;
        w_err       = r_err;
        w_res_id    = r_res_id;
        w_done_cnt  = r_done_cnt;
        w_fail_cnt  = r_fail_cnt;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_res_id  = r_next_id;
                    w_next_id = r_next_id + 8'd1;
                    if (w_len_bad) begin
                        // rejected job: core_in keeps the last good descriptor
                        w_err       = 1'b1;
                        w_auth_fail = 1'b0;
                        w_res_ct    = '0;
                        w_res_pt    = '0;
                        w_state     = S_RESULT;
                    end else begin
                        w_core_in = bus.job_word;
                        w_cnt     = CNT_W'(SETTLE - 1);
                        w_state   = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // abort wins over the final-cycle capture
                if (abort) begin
                    w_state = S_IDLE;
                end else if (r_cnt == '0) begin
                    w_res_ct    = core_ct;
                    w_res_pt    = core_pt;
                    w_auth_fail = &core_pt;
                    w_err       = 1'b0;
                    w_state     = S_RESULT;
                end else begin
                    w_cnt = r_cnt - CNT_W'(1);
                end
            end
            S_RESULT: begin
                if (bus.res_ready) begin
                    w_done_cnt = r_done_cnt + 16'd1;
                    if (r_auth_fail && (r_fail_cnt != 16'hFFFF)) begin
                        w_fail_cnt = r_fail_cnt + 16'd1;
                    end
                    w_state = S_IDLE;
                end
            end
            default: w_state = S_IDLE;
        endcase

        w_job_ready = (w_state == S_IDLE);
        w_res_valid = (w_state == S_RESULT);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_next_id   <= '0;
            r_core_in   <= '0;
            r_job_ready <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_ct    <= '0;
            r_res_pt    <= '0;
            r_auth_fail <= 1'b0;
            r_err       <= 1'b0;
            r_res_id    <= '0;
            r_done_cnt  <= '0;
            r_fail_cnt  <= '0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_next_id   <= w_next_id;
            r_core_in   <= w_core_in;
            r_job_ready <= w_job_ready;
            r_res_valid <= w_res_valid;
            r_res_ct    <= w_res_ct;
            r_res_pt    <= w_res_pt;
            r_auth_fail <= w_auth_fail;
            r_err       <= w_err;
            r_res_id    <= w_res_id;
            r_done_cnt  <= w_done_cnt;
            r_fail_cnt  <= w_fail_cnt;
        end
    end

    assign bus.job_ready     = r_job_ready;
    assign bus.res_valid     = r_res_valid;
    assign bus.res_ct        = r_res_ct;
    assign bus.res_pt        = r_res_pt;
    assign bus.res_auth_fail = r_auth_fail;
    assign bus.res_err       = r_err;
    assign bus.res_id        = r_res_id;
    assign core_in           = r_core_in;
    assign done_cnt          = r_done_cnt;
    assign fail_cnt          = r_fail_cnt;
endmodule

// File: tb/tb_ascon_job_ctrl.sv
// Directed bench for ascon_job_ctrl with a scoreboard and a model core that
// only returns correct outputs after SETTLE stable cycles of core_in.
module tb_ascon_job_ctrl;
    localparam int unsigned SETTLE = 24;
    localparam int unsigned MAXLEN = 4;

    typedef struct {
        logic [383:0] ct;
        logic [255:0] pt;
        logic         af;
        logic         err;
        logic [7:0]   id;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [191:0] core_in;
    logic [383:0] core_ct;
    logic [255:0] core_pt;
    logic         abort = 1'b0;
    logic [15:0]  done_cnt;
    logic [15:0]  fail_cnt;

    ascon_job_ctrl_if bus();

    ascon_job_ctrl #(.SETTLE(SETTLE), .MAXLEN(MAXLEN)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .core_in  (core_in),
        .core_ct  (core_ct),
        .core_pt  (core_pt),
        .abort    (abort),
        .done_cnt (done_cnt),
        .fail_cnt (fail_cnt)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    exp_t         sb[$];
    exp_t         cur;
    logic [7:0]   exp_id = '0;
    logic [15:0]  exp_done = '0;
    logic [15:0]  exp_fail = '0;
    logic [191:0] last_core = '0;

    function automatic logic [383:0] m_ct(input logic [191:0] d);
        return {d, ~d};
    endfunction

    function automatic logic [255:0] m_pt(input logic [191:0] d);
        if (d[63:32] == 32'hDEAD_BEEF) return '1;
        return {64'h0, d};
    endfunction

    function automatic logic [191:0] mk(input logic [31:0] ad, input logic [31:0] adl,
                                        input logic [31:0] msg, input logic [31:0] ml,
                                        input logic [31:0] cad, input logic [31:0] cadl);
        return {ad, adl, msg, ml, cad, cadl};
    endfunction

    // Model core: garbage until core_in has been stable for SETTLE cycles
    logic [191:0] m_last = '0;
    int           m_stable = 1000;
    logic [31:0]  noise = '0;
    logic         noise_en = 1'b0;
    always @(negedge clk) begin
        if (core_in !== m_last) begin
            m_last   = core_in;
            m_stable = 1;
        end else if (m_stable < 1000) begin
            m_stable = m_stable + 1;
        end
        noise = noise + 32'd1;
    end
    assign core_ct = (m_stable >= int'(SETTLE)) ?
                     (m_ct(core_in) ^ (noise_en ? {12{noise}} : 384'h0)) : ~m_ct(core_in);
    assign core_pt = (m_stable >= int'(SETTLE)) ?
                     (m_pt(core_in) ^ (noise_en ? {8{noise}} : 256'h0)) : ~m_pt(core_in);

    task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset();
        check("rst_job_ready", 384'(bus.job_ready), 384'(0));
        check("rst_res_valid", 384'(bus.res_valid), 384'(0));
        check("rst_auth_fail", 384'(bus.res_auth_fail), 384'(0));
        check("rst_err", 384'(bus.res_err), 384'(0));
        check("rst_core_in", 384'(core_in), 384'(0));
        check("rst_res_ct", bus.res_ct, 384'(0));
        check("rst_res_pt", 384'(bus.res_pt), 384'(0));
        check("rst_res_id", 384'(bus.res_id), 384'(0));
        check("rst_done_cnt", 384'(done_cnt), 384'(0));
        check("rst_fail_cnt", 384'(fail_cnt), 384'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        check_reset();
        rst = 1'b0;
        exp_id = '0; exp_done = '0; exp_fail = '0; last_core = '0;
        sb.delete();
        tick();
        check("job_ready_after_rst", 384'(bus.job_ready), 384'(1));
    endtask

    // Offer a descriptor, wait for acceptance; returns just after edge A
    task automatic send_job(input logic [191:0] w, input bit track);
        int   n;
        bit   bad;
        exp_t e;
        logic [255:0] p;
        n = 0;
        bus.job_valid = 1'b1;
        bus.job_word  = w;
        while (bus.job_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("accept_wait", 384'(n < 100), 384'(1));
        tick();
        bus.job_valid = 1'b0;
        bad = (w[159:128] > MAXLEN) || (w[95:64] > MAXLEN);
        p = m_pt(w);
        e.id   = exp_id;
        exp_id = exp_id + 8'd1;
        e.err  = bad;
        e.ct   = bad ? 384'h0 : m_ct(w);
        e.pt   = bad ? 256'h0 : p;
        e.af   = !bad && (&p);
        if (!bad) last_core = w;
        if (track) sb.push_back(e);
    endtask

    task automatic check_fields(input string pfx);
        check({pfx, "_res_ct"}, bus.res_ct, cur.ct);
        check({pfx, "_res_pt"}, 384'(bus.res_pt), 384'(cur.pt));
        check({pfx, "_auth_fail"}, 384'(bus.res_auth_fail), 384'(cur.af));
        check({pfx, "_res_err"}, 384'(bus.res_err), 384'(cur.err));
        check({pfx, "_res_id"}, 384'(bus.res_id), 384'(cur.id));
        check({pfx, "_core_in"}, 384'(core_in), 384'(last_core));
    endtask

    // Wait for res_valid; exp_lat counts edges after the acceptance edge
    task automatic wait_res(input int exp_lat);
        int lat;
        lat = 0;
        while (bus.res_valid !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        check("res_latency", 384'(lat), 384'(exp_lat));
        check("sb_entries", 384'(sb.size()), 384'(1));
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            check_fields("res");
        end
    endtask

    // Optionally stall in RESULT with noisy core and ignored job offer, then take it
    task automatic finish_res(input int hold);
        if (hold > 0) begin
            noise_en      = 1'b1;
            bus.job_valid = 1'b1;
            bus.job_word  = mk(32'h1, 32'h1, 32'h2, 32'h1, 32'h3, 32'h4);
            repeat (hold) tick();
            check_fields("hold");
            check("hold_res_valid", 384'(bus.res_valid), 384'(1));
            check("hold_job_ready", 384'(bus.job_ready), 384'(0));
            bus.job_valid = 1'b0;
            noise_en      = 1'b0;
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        exp_done = exp_done + 16'd1;
        if (cur.af && exp_fail != 16'hFFFF) exp_fail = exp_fail + 16'd1;
        check("hs_res_valid", 384'(bus.res_valid), 384'(0));
        check("hs_job_ready", 384'(bus.job_ready), 384'(1));
        check("done_cnt", 384'(done_cnt), 384'(exp_done));
        check("fail_cnt", 384'(fail_cnt), 384'(exp_fail));
    endtask

    task automatic check_aborted();
        check("abort_res_valid", 384'(bus.res_valid), 384'(0));
        check("abort_job_ready", 384'(bus.job_ready), 384'(1));
        check("abort_done_cnt", 384'(done_cnt), 384'(exp_done));
        check("abort_fail_cnt", 384'(fail_cnt), 384'(exp_fail));
        repeat (SETTLE + 2) tick();
        check("abort_no_result", 384'(bus.res_valid), 384'(0));
    endtask

    initial begin
        bus.job_valid = 1'b0;
        bus.job_word  = '0;
        bus.res_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Good job, lengths 4/4, pt ends in ...01
        send_job(mk(32'hA1A2A3A4, 32'd4, 32'hB1B2B3B4, 32'd4, 32'hC1C2C3C4, 32'd1), 1'b1);
        wait_res(SETTLE);
        finish_res(0);

        // Tag mismatch job
        send_job(mk(32'h11111111, 32'd2, 32'h22222222, 32'd3, 32'hDEADBEEF, 32'd0), 1'b1);
        wait_res(SETTLE);
        finish_res(0);

        // Length errors: AD length 5, msg length 0x100, huge AD length
        send_job(mk(32'h33333333, 32'd5, 32'h44444444, 32'd0, 32'h0, 32'h0), 1'b1);
        wait_res(0);
        finish_res(0);
        send_job(mk(32'h55555555, 32'd0, 32'h66666666, 32'h100, 32'h0, 32'h0), 1'b1);
        wait_res(0);
        finish_res(0);
        send_job(mk(32'h77777777, 32'h8000_0000, 32'h88888888, 32'd4, 32'h0, 32'h0), 1'b1);
        wait_res(0);
        finish_res(0);

        // res_ready already high when the result appears
        bus.res_ready = 1'b1;
        send_job(mk(32'h99999999, 32'd6, 32'h0, 32'd0, 32'h0, 32'h0), 1'b1);
        wait_res(0);
        finish_res(0);

        // Abort mid-run
        send_job(mk(32'hAB000001, 32'd1, 32'hAB000002, 32'd1, 32'h0, 32'h7), 1'b0);
        repeat (9) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_aborted();

        // Abort in the final RUN cycle
        send_job(mk(32'hAC000001, 32'd2, 32'hAC000002, 32'd2, 32'h0, 32'h8), 1'b0);
        repeat (SETTLE - 1) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_aborted();

        // Next job skips both aborted ids; then a 50-cycle stall in RESULT
        send_job(mk(32'hAD000001, 32'd3, 32'hAD000002, 32'd0, 32'h0, 32'h9), 1'b1);
        wait_res(SETTLE);
        finish_res(50);

        // fail_cnt saturation
        force dut.r_fail_cnt = 16'hFFFE;
        #1;
        release dut.r_fail_cnt;
        exp_fail = 16'hFFFE;
        send_job(mk(32'hF0000001, 32'd1, 32'hF0000002, 32'd1, 32'hDEADBEEF, 32'd1), 1'b1);
        wait_res(SETTLE);
        finish_res(0);
        send_job(mk(32'hF0000003, 32'd1, 32'hF0000004, 32'd1, 32'hDEADBEEF, 32'd2), 1'b1);
        wait_res(SETTLE);
        finish_res(0);

        // 256 error jobs to wrap the id
        for (int i = 0; i < 256; i++) begin
            send_job(mk(32'(i), 32'd9, 32'(i), 32'd0, 32'h0, 32'h0), 1'b1);
            wait_res(0);
            finish_res(0);
        end

        // Reset mid-RUN
        send_job(mk(32'hE0000001, 32'd1, 32'hE0000002, 32'd1, 32'h0, 32'h0), 1'b0);
        repeat (5) tick();
        do_reset();

        // Reset mid-RESULT
        send_job(mk(32'hE1000001, 32'd4, 32'hE1000002, 32'd4, 32'h0, 32'h5), 1'b1);
        wait_res(SETTLE);
        do_reset();

        // Post-reset job restarts ids at 0
        send_job(mk(32'hE2000001, 32'd0, 32'hE2000002, 32'd4, 32'h0, 32'h6), 1'b1);
        wait_res(SETTLE);
        finish_res(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
